// File: rtl/flappy_pkg.sv
// Shared types for the flappy game-state/scoring slice: FSM state encoding,
// BCD digit type and the default score width.
package flappy_pkg;

    localparam int unsigned DIGITS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit packed BCD counter with synchronous clear and increment;
// saturates at all-nines instead of wrapping.
module bcd_counter
    import flappy_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   bcd
);

    bcd_digit_t [DIGITS-1:0] digit_q;
    bcd_digit_t [DIGITS-1:0] digit_d;
    logic                    all_nines;
    logic                    carry;

    always_comb begin
        all_nines = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_q[i] != 4'd9) begin
                all_nines = 1'b0;
            end
        end
    end

    // Ripple the carry from digit0 upward; the chain stops at the first non-9 digit.
    always_comb begin
        digit_d = digit_q;
        carry   = inc & ~all_nines;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digit_q[i] == 4'd9) begin
                    digit_d[i] = '0;
                end else begin
                    digit_d[i] = digit_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign bcd = digit_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Per-frame collision/pass judgement, IDLE/PLAY/DYING/DEAD game FSM and BCD score.
// Define HIGH_SCORE_EN to build the best-score register behind hi_bcd.
module game_score_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned BIRD_X     = 200,
    parameter int unsigned PIPE_W     = 40,
    parameter int unsigned GAP_H      = 120,
    parameter int unsigned DEATH_HOLD = 60,
    parameter int unsigned DIGITS     = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                start,
    input  logic [Y_W-1:0]      bird_y,
    input  logic [X_W-1:0]      pipe_x,
    input  logic [Y_W-1:0]      gap_y,
    input  logic                floor_hit,
    output logic [1:0]          state,
    output logic                is_dead,
    output logic                score_pulse,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] hi_bcd
);

    localparam int unsigned       HOLD_W     = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
    localparam logic [X_W:0]      BIRD_X_EXT = (X_W+1)'(BIRD_X);
    localparam logic [X_W:0]      PIPE_W_EXT = (X_W+1)'(PIPE_W);
    localparam logic [Y_W:0]      GAP_H_EXT  = (Y_W+1)'(GAP_H);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(DEATH_HOLD - 1);

    game_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [X_W:0]      trail, prev_trail;
    logic [Y_W:0]      gap_end;
    logic              in_column, outside_gap, hit, pass;
    logic              score_clear, score_inc, pulse_d;

    assign trail       = {1'b0, pipe_x} + PIPE_W_EXT;
    assign gap_end     = {1'b0, gap_y} + GAP_H_EXT;
    assign in_column   = (BIRD_X_EXT >= {1'b0, pipe_x}) && (BIRD_X_EXT < trail);
    assign outside_gap = ({1'b0, bird_y} < {1'b0, gap_y}) || ({1'b0, bird_y} >= gap_end);
    assign hit         = floor_hit || (in_column && outside_gap);
    // A respawn moves the trailing edge right of the bird, so it can never look like a crossing.
    assign pass        = (prev_trail > BIRD_X_EXT) && (trail <= BIRD_X_EXT);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        score_clear = 1'b0;
        score_inc   = 1'b0;
        pulse_d     = 1'b0;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = PLAY;
                        score_clear = 1'b1;
                    end
                end
                PLAY: begin
                    if (hit) begin
                        state_d = DYING;
                        hold_d  = HOLD_LOAD;
                    end else if (pass) begin
                        score_inc = 1'b1;
                        pulse_d   = 1'b1;
                    end
                end
                DYING: begin
                    if (hold_q == '0) begin
                        state_d = DEAD;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                DEAD: begin
                    if (start) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            prev_trail  <= '0;
            is_dead     <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            is_dead     <= (state_d == DYING) || (state_d == DEAD);
            score_pulse <= pulse_d;
            if (frame_tick) begin
                prev_trail <= trail;
            end
        end
    end

    assign state = state_q;

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .bcd   (score_bcd)
    );

`ifdef HIGH_SCORE_EN
    logic [4*DIGITS-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
        end else if (state_q == DYING && state_d == DEAD && score_bcd > hi_q) begin
            hi_q <= score_bcd;
        end
    end

    assign hi_bcd = hi_q;
`else
    assign hi_bcd = '0;
`endif

endmodule
